pdm_recorder: RTL and testbench

Capture-side counterpart to the sample-ROM/PWM playback path. Generates the microphone bit clock, demodulates the 1-bit PDM microphone stream into 8-bit unsigned samples by ones-counting over a fixed decimation window, and writes each sample into a sample RAM at incrementing addresses. Software starts and stops recording. The filled RAM is later replayed through the existing playback chain.

---
 rtl/audio_pkg.sv | 14 +
 rtl/pdm_clk_gen.sv | 33 +++
 rtl/pdm_recorder.sv | 122 ++++++++++++
 tb/tb_pdm_recorder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio capture and playback blocks.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } rec_state_t;

  localparam int SAMPLE_W        = 8;
  localparam int DEFAULT_CLK_DIV = 40;
  localparam int DEFAULT_DECIM   = 128;

endpackage

// File: rtl/pdm_clk_gen.sv
// Free-running microphone bit clock with a one-cycle strobe on the last
// system clock of each high phase, where the PDM bit is sampled.
module pdm_clk_gen import audio_pkg::*; #(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic pdm_clk,
  output logic bit_strobe
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;

  assign div_nxt    = (div_cnt == LAST) ? '0 : div_cnt + DIV_W'(1);
  assign bit_strobe = (div_cnt == HALF - DIV_W'(1));

  // pdm_clk is registered from the next count so it stays aligned with div_cnt
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      pdm_clk <= (div_nxt < HALF);
    end
  end

endmodule

// File: rtl/pdm_recorder.sv
// PDM microphone capture: ones-count decimation into 8-bit samples written to RAM.
// Define RECORDER_LOOP_EN to wrap the address after MAX_ADDR and keep recording until stop.
module pdm_recorder import audio_pkg::*; #(
  parameter int CLK_DIV  = DEFAULT_CLK_DIV,
  parameter int DECIM    = DEFAULT_DECIM,
  parameter int ADDR_W   = 16,
  parameter int MAX_ADDR = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                record,
  input  logic                stop,
  input  logic                pdm_data,
  output logic                pdm_clk,
  output logic                mic_lrsel,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     sample_count
);

  localparam int LOG2_DECIM = $clog2(DECIM);
  localparam int CNT_W      = LOG2_DECIM + 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DECIM - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR);
`ifdef RECORDER_LOOP_EN
  localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W + 1)'(MAX_ADDR + 1);
`endif

  rec_state_t state, state_nxt;

  logic                bit_strobe;
  logic                start;
  logic                bit_take;
  logic                win_end;
  logic [CNT_W-1:0]    ones;
  logic [CNT_W-1:0]    bits;
  logic [CNT_W-1:0]    win_total;
  logic [SAMPLE_W:0]   scaled;
  logic [SAMPLE_W-1:0] sample;

  pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .pdm_clk    (pdm_clk),
    .bit_strobe (bit_strobe)
  );

  assign mic_lrsel = 1'b0;
  assign busy      = (state == CAPTURE);
  assign done      = (state == DONE);

  // stop outranks record everywhere, including the strobe that would close a window
  assign start     = (state != CAPTURE) && record && !stop;
  assign bit_take  = (state == CAPTURE) && !stop && bit_strobe;
  assign win_end   = bit_take && (bits == LAST_BIT);
  assign win_total = ones + CNT_W'(pdm_data);
  assign scaled    = (SAMPLE_W + 1)'(win_total) << (SAMPLE_W - LOG2_DECIM);
  assign sample    = scaled[SAMPLE_W] ? '1 : scaled[SAMPLE_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = CAPTURE;
      CAPTURE: begin
        if (stop) state_nxt = DONE;
`ifndef RECORDER_LOOP_EN
        else if (win_end && (wr_addr == LAST_ADDR)) state_nxt = DONE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The write strobe is issued the cycle after the window closes; address and
  // count advance one cycle later still, so wr_addr is stable during wr_en.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      sample_count <= '0;
      ones         <= '0;
      bits         <= '0;
    end else begin
      wr_en <= win_end;
      if (win_end) wr_data <= sample;
      if (start) begin
        wr_addr      <= '0;
        sample_count <= '0;
        ones         <= '0;
        bits         <= '0;
      end else begin
        if (wr_en) begin
          wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_W'(1);
`ifdef RECORDER_LOOP_EN
          if (sample_count != MAX_COUNT) sample_count <= sample_count + (ADDR_W + 1)'(1);
`else
          sample_count <= sample_count + (ADDR_W + 1)'(1);
`endif
        end
        if (bit_take) begin
          if (win_end) begin
            ones <= '0;
            bits <= '0;
          end else begin
            ones <= win_total;
            bits <= bits + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_recorder.sv
// Randomized bench for pdm_recorder against a window-level reference model.
// Honors RECORDER_LOOP_EN when defined for the build.
module tb_pdm_recorder;

  localparam int CLK_DIV  = 4;
  localparam int DECIM    = 8;
  localparam int ADDR_W   = 4;
  localparam int MAX_ADDR = 3;
  localparam int N_ADDR   = MAX_ADDR + 1;
  localparam int WIN_CLKS = CLK_DIV * DECIM;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic record = 1'b0;
  logic stop = 1'b0;
  logic pdm_data = 1'b0;
  logic pdm_clk, mic_lrsel, wr_en, busy, done;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W:0]   sample_count;

  int n_checks = 0;
  int n_fails  = 0;
  int mode = 0;
  int wr_seen = 0;
  int first_addr = -1;

  int m_phase = 0;
  bit m_in_rst = 1'b1;
  bit m_started = 1'b0;
  bit m_cap = 1'b0;
  bit m_done = 1'b0;
  bit m_pend = 1'b0;
  int m_addr = 0;
  int m_count = 0;
  int m_ones = 0;
  int m_nbits = 0;
  bit exp_wr = 1'b0;
  int exp_addr = 0;
  int exp_data = 0;

  always #5 clk = ~clk;

  pdm_recorder #(
    .CLK_DIV  (CLK_DIV),
    .DECIM    (DECIM),
    .ADDR_W   (ADDR_W),
    .MAX_ADDR (MAX_ADDR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .record       (record),
    .stop         (stop),
    .pdm_data     (pdm_data),
    .pdm_clk      (pdm_clk),
    .mic_lrsel    (mic_lrsel),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count)
  );

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a capture collects one bit per microphone clock period,
  // every DECIM bits become one sample = min(ones * 256/DECIM, 255).
  always @(posedge clk) begin
    bit strobe;
    m_started = 1'b1;
    if (!rst) begin
      m_phase = 0; m_in_rst = 1'b1; m_cap = 1'b0; m_done = 1'b0;
      m_pend = 1'b0; m_count = 0; m_addr = 0; exp_wr = 1'b0;
      m_ones = 0; m_nbits = 0;
    end else begin
      strobe   = (m_phase == CLK_DIV / 2 - 1);
      m_phase  = (m_phase + 1) % CLK_DIV;
      m_in_rst = 1'b0;
      if (m_pend) begin
`ifdef RECORDER_LOOP_EN
        if (m_count < N_ADDR) m_count++;
`else
        m_count++;
`endif
      end
      m_pend = 1'b0;
      exp_wr = 1'b0;
      if (m_cap) begin
        if (stop) begin
          m_cap = 1'b0; m_done = 1'b1;
        end else if (strobe) begin
          m_ones += int'(pdm_data);
          m_nbits++;
          if (m_nbits == DECIM) begin
            exp_wr   = 1'b1;
            exp_addr = m_addr;
            exp_data = (m_ones * (256 / DECIM) > 255) ? 255 : m_ones * (256 / DECIM);
            m_pend   = 1'b1;
            m_ones   = 0;
            m_nbits  = 0;
            m_addr   = (m_addr + 1) % N_ADDR;
`ifndef RECORDER_LOOP_EN
            if (exp_addr == MAX_ADDR) begin
              m_cap = 1'b0; m_done = 1'b1;
            end
`endif
          end
        end
      end else if (record && !stop) begin
        m_cap = 1'b1; m_done = 1'b0; m_addr = 0; m_count = 0;
        m_ones = 0; m_nbits = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check_output("pdm_clk", pdm_clk, (!m_in_rst && (m_phase < CLK_DIV / 2)) ? 1 : 0);
      check_output("mic_lrsel", mic_lrsel, 0);
      check_output("busy", busy, m_cap);
      check_output("done", done, m_done);
      check_output("sample_count", sample_count, m_count);
      check_output("wr_en", wr_en, exp_wr);
      if (m_in_rst) begin
        check_output("wr_addr_rst", wr_addr, 0);
        check_output("wr_data_rst", wr_data, 0);
      end
      if (exp_wr) begin
        check_output("wr_addr", wr_addr, exp_addr);
        check_output("wr_data", wr_data, exp_data);
        if (mode < 3) check_output("wr_data_const", wr_data, (mode == 1) ? 255 : ((mode == 2) ? 128 : 0));
      end
      if (wr_en) begin
        wr_seen++;
        if (first_addr < 0) first_addr = int'(wr_addr);
      end
    end
  end

  // Microphone stand-in: the alternating pattern flips once per bit period
  always @(negedge clk) begin
    case (mode)
      0: pdm_data = 1'b0;
      1: pdm_data = 1'b1;
      2: if (m_phase == 0) pdm_data = ~pdm_data;
      default: pdm_data = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic apply_stimulus(input logic r, input logic rec, input logic stp, input int n);
    rst = r; record = rec; stop = stp;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget && wr_seen < n; i++) @(negedge clk);
    check_output("wait_writes", (wr_seen >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) @(negedge clk);
    check_output("wait_done", done, 1);
  endtask

  task automatic run_full(input int m);
    mode = m; wr_seen = 0; first_addr = -1;
    apply_stimulus(1, 1, 0, 1);
    apply_stimulus(1, 0, 0, 1);
`ifdef RECORDER_LOOP_EN
    wait_writes(6, 8 * WIN_CLKS);
    apply_stimulus(1, 0, 0, 3);
    check_output("loop_busy", busy, 1);
    apply_stimulus(1, 0, 1, 1);
    apply_stimulus(1, 0, 0, 2);
    check_output("loop_writes", wr_seen, 6);
`else
    wait_done(8 * WIN_CLKS);
    apply_stimulus(1, 0, 0, 2);
    check_output("full_writes", wr_seen, N_ADDR);
`endif
    check_output("full_first_addr", first_addr, 0);
    check_output("full_count", sample_count, N_ADDR);
    check_output("full_done", done, 1);
    check_output("full_busy", busy, 0);
  endtask

  initial begin
    int rise0, rise1;
    @(negedge clk);
    apply_stimulus(0, 0, 0, 3);
    check_output("rst_wr_en", wr_en, 0);
    check_output("rst_busy", busy, 0);
    apply_stimulus(1, 0, 0, 6);

    $display("[TB] full captures: ones, alternating, zeros, random");
    run_full(1);
    run_full(2);
    run_full(0);
    run_full(3);

    $display("[TB] stop mid-window after second write");
    mode = 3; wr_seen = 0;
    apply_stimulus(1, 1, 0, 1);
    apply_stimulus(1, 0, 0, 1);
    wait_writes(2, 4 * WIN_CLKS);
    apply_stimulus(1, 0, 0, WIN_CLKS / 3);
    apply_stimulus(1, 0, 1, 1);
    apply_stimulus(1, 0, 0, 2 * WIN_CLKS);
    check_output("stop_writes", wr_seen, 2);
    check_output("stop_count", sample_count, 2);
    check_output("stop_done", done, 1);

    $display("[TB] record and stop together from idle");
    apply_stimulus(0, 0, 0, 2);
    apply_stimulus(1, 0, 0, 3);
    wr_seen = 0; first_addr = -1;
    apply_stimulus(1, 1, 1, 6);
    check_output("both_busy", busy, 0);
    check_output("both_done", done, 0);
    apply_stimulus(1, 0, 0, WIN_CLKS + 4);
    check_output("both_writes", wr_seen, 0);
    apply_stimulus(1, 1, 0, 1);
    apply_stimulus(1, 0, 0, 1);
    wait_writes(1, 3 * WIN_CLKS);
    check_output("restart_addr", first_addr, 0);
    apply_stimulus(1, 0, 0, 5);

    $display("[TB] reset during capture");
    apply_stimulus(0, 0, 0, 1);
    check_output("abort_busy", busy, 0);
    check_output("abort_wr_en", wr_en, 0);
    check_output("abort_pdm_clk", pdm_clk, 0);
    check_output("abort_count", sample_count, 0);
    apply_stimulus(1, 0, 0, 1);
    rise0 = -1; rise1 = -1;
    for (int i = 0; i < 20 && rise1 < 0; i++) begin
      logic prev;
      prev = pdm_clk;
      @(negedge clk);
      if (!prev && pdm_clk) begin
        if (rise0 < 0) rise0 = i;
        else rise1 = i;
      end
    end
    check_output("pdm_clk_period", (rise1 >= 0) ? rise1 - rise0 : -1, CLK_DIV);
    wr_seen = 0;
    apply_stimulus(1, 0, 0, 2 * WIN_CLKS);
    check_output("abort_no_writes", wr_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
